mdu_seq: RTL and testbench

- Iterative multiply/divide sequencer for the RV64 core's M-extension ops, driven when the decoder flags `muldiv`.
- Latches operands and destination register, then runs a shift-add multiplier or restoring divider one bit per cycle.
- Holds the pipeline stalled while running, then presents the result for one cycle to the writeback mux.

---
 rtl/mdu_seq_if.sv | 37 +++
 rtl/mdu_seq.sv | 191 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_if
// Purpose  : Issue/result bundle between the decode/execute stage and the
//            iterative multiply/divide sequencer.
// Signals  : start, op[2:0], word, a, b, rd_in, flush  -> requester drives
//            busy, stall, done, result, rd_out         -> sequencer drives
// Modports : master (requester side), slave (sequencer side)
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_seq_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, word, a, b, rd_in, flush,
    input  busy, stall, done, result, rd_out
  );

  modport slave (
    input  start, op, word, a, b, rd_in, flush,
    output busy, stall, done, result, rd_out
  );
endinterface
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Purpose  : Iterative RV64 M-extension unit. Shift-add multiply or restoring
//            divide, one bit per cycle; special divide cases skip iteration.
// Ports    : clk          - clock
//            rst          - synchronous active-high reset
//            bus (slave)  - start/op/word/a/b/rd_in/flush in,
//                           busy/stall/done/result/rd_out out
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  mdu_seq_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [4:0]        rd_q, rd_d;
  logic [5:0]        cnt_q, cnt_d;
  // x: multiplicand (shifted left) or divisor; y: multiplier (shifted right)
  // or dividend/quotient; acc: product or partial remainder.
  logic [2*XLEN-1:0] x_q, x_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   y_q, y_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_q, neg_d;    // negate product / quotient
  logic              negr_q, negr_d;  // negate remainder (dividend sign)

  // ---------------- operand forming (issue cycle) ----------------
  logic            is_div, div_signed, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg;

  assign is_div     = bus.op[2];
  assign div_signed = is_div & ~bus.op[0];
  // W multiplies only keep the low 32 bits, so signedness is irrelevant there.
  assign sgn_a = is_div ? div_signed : (~bus.word & ((bus.op == 3'd1) | (bus.op == 3'd2)));
  assign sgn_b = is_div ? div_signed : (~bus.word & (bus.op == 3'd1));
  assign a_ext = bus.word ? {{(XLEN-32){sgn_a & bus.a[31]}}, bus.a[31:0]} : bus.a;
  assign b_ext = bus.word ? {{(XLEN-32){sgn_b & bus.b[31]}}, bus.b[31:0]} : bus.b;
  assign a_neg = sgn_a & a_ext[XLEN-1];
  assign b_neg = sgn_b & b_ext[XLEN-1];
  assign mag_a = a_neg ? -a_ext : a_ext;
  assign mag_b = b_neg ? -b_ext : b_ext;
  assign min_neg  = bus.word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign div_ovf  = div_signed & (a_ext == min_neg) & (b_ext == '1);

  // ---------------- restoring divide step ----------------
  logic [XLEN:0] r_sh, r_sub;
  logic          q_bit;
  logic [5:0]    last_cnt;

  assign r_sh     = {acc_q[XLEN-1:0], y_q[XLEN-1]};
  assign r_sub    = r_sh - {1'b0, x_q[XLEN-1:0]};
  // r_sh < 2*divisor, so a non-negative difference never sets the top bit.
  assign q_bit    = ~r_sub[XLEN];
  assign last_cnt = word_q ? 6'd31 : 6'd63;

  // ---------------- sign fix and result select ----------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, sel;

  assign prod = neg_q  ? -acc_q : acc_q;
  assign quo  = neg_q  ? -y_q   : y_q;
  assign rem  = negr_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign sel  = op_q[2] ? (op_q[1] ? rem : quo)
                        : (((op_q == 3'd0) | word_q) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    acc_d    = acc_q;
    y_d      = y_q;
    result_d = result_q;
    neg_d    = neg_q;
    negr_d   = negr_q;

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_d   = bus.op;
            word_d = bus.word;
            rd_d   = bus.rd_in;
            cnt_d  = '0;
            acc_d  = '0;
            if (is_div & (div_zero | div_ovf)) begin
              // Preload quotient/remainder so FIX only has to select.
              neg_d   = 1'b0;
              negr_d  = 1'b0;
              x_d     = '0;
              y_d     = div_zero ? '1 : a_ext;
              acc_d   = div_zero ? {{XLEN{1'b0}}, a_ext} : '0;
              state_d = FIX;
            end else begin
              neg_d   = a_neg ^ b_neg;
              negr_d  = a_neg;
              x_d     = {{XLEN{1'b0}}, (is_div ? mag_b : mag_a)};
              // W divides only run 32 steps, so park the dividend in the top half.
              y_d     = is_div ? (bus.word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a) : mag_b;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc_d = {{XLEN{1'b0}}, (q_bit ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0])};
            y_d   = {y_q[XLEN-2:0], q_bit};
          end else begin
            if (y_q[0]) begin
              acc_d = acc_q + x_q;
            end
            x_d = x_q << 1;
            y_d = y_q >> 1;
          end
          if (cnt_q == last_cnt) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        FIX: begin
          result_d = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
          state_d  = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      rd_q     <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;
  // Released in DONE so the consuming stage advances together with the result.
  assign bus.stall  = ((state_q == IDLE) & bus.start) | (state_q == CALC) | (state_q == FIX);
endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq
// Purpose  : Self-checking bench for mdu_seq: directed vector table, corner
//            sequences (flush, reset, ignored starts) and randomized ops
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mdu_seq_if #(.XLEN(64)) bus ();

  mdu_seq #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  logic [63:0] snap_res;
  logic [4:0]  snap_rd;
  logic        snap_busy;
  logic        snap_done;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // Reference: RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, r;
    logic [127:0]       p;
    logic [63:0]        mn;
    if (w) begin
      sa = sx32(a); sb = sx32(b);
      ua = {32'd0, a[31:0]}; ub = {32'd0, b[31:0]};
      case (op)
        3'd4: r = (ub == 0) ? '1 : 64'(sa / sb);
        3'd5: r = (ub == 0) ? '1 : ua / ub;
        3'd6: r = (ub == 0) ? 64'(sa) : 64'(sa % sb);
        3'd7: r = (ub == 0) ? 64'(sa) : ua % ub;
        default: r = a * b;
      endcase
      return sx32(r);
    end
    sa = a; sb = b;
    mn = 64'h8000_0000_0000_0000;
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
      3'd4: r = (b == 0) ? '1 : ((a == mn && b == '1) ? a : 64'(sa / sb));
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: r = (b == 0) ? a : ((a == mn && b == '1) ? 64'd0 : 64'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic bz, ovf;
    bz  = w ? (b[31:0] == 0) : (b == 0);
    ovf = (op == 3'd4 || op == 3'd6) &&
          (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
             : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (op[2] && (bz || ovf)) return 2;
    return w ? 34 : 66;
  endfunction

  // Issue one op and wait for done. inj_kind: 0 none, 1 start pulse, 2 flush,
  // 3 reset, applied for one cycle at cycle inj_cyc; the state one cycle later
  // is captured in snap_*.
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] x,
                        input logic [63:0] y, input logic [4:0] r,
                        input int inj_cyc, input int inj_kind, input int max_cyc,
                        output logic [63:0] res, output int lat,
                        output logic [4:0] rdo, output bit st_ok);
    st_ok = 1'b1; lat = -1; res = '0; rdo = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.word = w; bus.a = x; bus.b = y; bus.rd_in = r;
    #1;
    if (!bus.stall) st_ok = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0; rst = 1'b0;
      if (c == inj_cyc) begin
        case (inj_kind)
          1: begin bus.start = 1'b1; bus.op = 3'd5; bus.a = 64'd100; bus.b = 64'd0; bus.rd_in = 5'd31; end
          2: bus.flush = 1'b1;
          3: rst = 1'b1;
          default: ;
        endcase
      end
      #1;
      if (c == inj_cyc + 1) begin
        snap_busy = bus.busy; snap_done = bus.done; snap_res = bus.result; snap_rd = bus.rd_out;
      end
      if (bus.done) begin
        lat = c; res = bus.result; rdo = bus.rd_out;
        if (bus.stall) st_ok = 1'b0;
        break;
      end
      if (inj_kind < 2 && !bus.stall) st_ok = 1'b0;
    end
    bus.start = 1'b0; bus.flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [63:0] res, a, b;
    logic [4:0]  rdo;
    logic [2:0]  op;
    logic        w;
    int          lat;
    bit          st_ok;

    total = 0; bad = 0;
    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    vecs[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 66};
    vecs[2]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66};
    vecs[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[4]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[5]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[6]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66};
    vecs[7]  = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66};
    vecs[8]  = '{3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[9]  = '{3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 2};
    vecs[10] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    vecs[11] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    vecs[12] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[13] = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
    vecs[14] = '{3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[15] = '{3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h0000_0000_0FFF_FFFF, 34};

    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.word = 1'b0; bus.a = '0; bus.b = '0;
    bus.rd_in = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy",   64'(bus.busy),   64'd0);
    chk("reset_done",   64'(bus.done),   64'd0);
    chk("reset_stall",  64'(bus.stall),  64'd0);
    chk("reset_result", bus.result,      64'd0);
    chk("reset_rd_out", 64'(bus.rd_out), 64'd0);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i + 1), 0, 0, 200, res, lat, rdo, st_ok);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_rd_out", i), 64'(rdo), 64'(i + 1));
      chk($sformatf("vec%0d_stall", i), 64'(st_ok), 64'd1);
    end

    // Flush mid-divide: no done, busy drops, old result kept.
    run_op(3'd7, 1'b0, 64'd100, 64'd7, 5'd3, 0, 0, 200, res, lat, rdo, st_ok);
    chk("pre_flush_result", res, 64'd2);
    run_op(3'd4, 1'b0, 64'd1000, 64'd3, 5'd4, 10, 2, 80, res, lat, rdo, st_ok);
    chk("flush_busy_next", 64'(snap_busy), 64'd0);
    chk("flush_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_result_kept", bus.result, 64'd2);

    run_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd9, 0, 0, 200, res, lat, rdo, st_ok);
    chk("mul3x5_result", res, 64'd15);
    chk("mul3x5_latency", 64'(lat), 64'd66);

    // A start pulse while busy must not disturb the running op.
    run_op(3'd0, 1'b0, 64'd6, 64'd7, 5'd12, 5, 1, 200, res, lat, rdo, st_ok);
    chk("busy_start_result", res, 64'd42);
    chk("busy_start_latency", 64'(lat), 64'd66);
    chk("busy_start_rd_out", 64'(rdo), 64'd12);

    // start during DONE is dropped, not queued.
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 64'd100; bus.b = 64'd0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("done_start_ignored", 64'(bus.busy), 64'd0);

    // flush together with start in IDLE: not accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    chk("flush_start_idle_busy", 64'(bus.busy), 64'd0);

    // Reset mid-CALC clears every output on the next cycle.
    run_op(3'd0, 1'b0, 64'd9, 64'd9, 5'd17, 10, 3, 20, res, lat, rdo, st_ok);
    chk("rst_calc_busy",   64'(snap_busy), 64'd0);
    chk("rst_calc_done",   64'(snap_done), 64'd0);
    chk("rst_calc_result", snap_res,       64'd0);
    chk("rst_calc_rd_out", 64'(snap_rd),   64'd0);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 20));
        3: begin b = '1; a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000; end
        default: b = {$urandom, $urandom};
      endcase
      run_op(op, w, a, b, 5'(i), 0, 0, 200, res, lat, rdo, st_ok);
      chk($sformatf("rnd%0d_op%0d_w%0d_result", i, op, w), res, ref_model(op, w, a, b));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(ref_lat(op, w, a, b)));
      chk($sformatf("rnd%0d_rd_out", i), 64'(rdo), 64'(i[4:0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
